// File: rtl/reg_bank_arbiter_pkg.sv
// reg_bank_arbiter_pkg
//   Shared opcode and state encodings for the register-bank arbiter.
//   No ports; imported by reg_bank_arbiter and rr_picker.
package reg_bank_arbiter_pkg;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_CLR   = 2'd2;
  localparam logic [1:0] OP_PRE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/reg_bank_arbiter_rr_picker.sv
// rr_picker
//   Combinational round-robin selection: first requester found searching
//   ptr, ptr+1, ... modulo NrOfReq.
// Ports:
//   req    in   NrOfReq  request levels
//   ptr    in   IdxW     search start index (always < NrOfReq)
//   grant  out  NrOfReq  one-hot winner (0 when nothing requested)
//   idx    out  IdxW     winner index
//   found  out  1        some requester is active
module rr_picker #(
  parameter int NrOfReq = 4,
  parameter int IdxW    = (NrOfReq > 1) ? $clog2(NrOfReq) : 1
) (
  input  logic [NrOfReq-1:0] req,
  input  logic [IdxW-1:0]    ptr,
  output logic [NrOfReq-1:0] grant,
  output logic [IdxW-1:0]    idx,
  output logic               found
);

  // Outer loop walks the search distance, inner loop the candidate index, so
  // every select below uses a loop constant rather than a computed index.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int d = 0; d < NrOfReq; d++) begin
      for (int k = 0; k < NrOfReq; k++) begin
        if (!found && req[k] && (((int'(ptr) + d) % NrOfReq) == k)) begin
          found    = 1'b1;
          grant[k] = 1'b1;
          idx      = IdxW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter
//   Shares one bank of clearable/presettable tri-state registers between
//   several requesters, one transaction at a time, round-robin.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | waiting for a request; picks owner and latches operands
//   ACCESS | one strobe active on the addressed register
//   DONE   | strobes off, ack pulse to owner, pointer moves past owner
//
// Ports:
//   Clock, Reset (sync, active-high), Tick (advance enable)
//   req/op/addr/wdata   per-requester request, opcode, address, data
//   bus_rd              shared register read bus
//   bus_wd              shared write data to register D inputs
//   reg_we/cs/clr/pre   per-register enable, output select (1=Z), clear, preset
//   grant, ack, err     owner, completion pulse, out-of-range flag
//   rdata, busy         read result (held), FSM not idle
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int NrOfReq  = 4,
  parameter int NrOfRegs = 8,
  parameter int AddrBits = 3,
  parameter int NrOfBits = 8
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Tick,
  input  logic [NrOfReq-1:0]           req,
  input  logic [2*NrOfReq-1:0]         op,
  input  logic [AddrBits*NrOfReq-1:0]  addr,
  input  logic [NrOfBits*NrOfReq-1:0]  wdata,
  input  logic [NrOfBits-1:0]          bus_rd,
  output logic [NrOfBits-1:0]          bus_wd,
  output logic [NrOfRegs-1:0]          reg_we,
  output logic [NrOfRegs-1:0]          reg_cs,
  output logic [NrOfRegs-1:0]          reg_clr,
  output logic [NrOfRegs-1:0]          reg_pre,
  output logic [NrOfReq-1:0]           grant,
  output logic [NrOfReq-1:0]           ack,
  output logic                         err,
  output logic [NrOfBits-1:0]          rdata,
  output logic                         busy
);

  localparam int IdxW = (NrOfReq > 1) ? $clog2(NrOfReq) : 1;

  state_t              state, state_n;
  logic [IdxW-1:0]     ptr, ptr_n;
  logic [IdxW-1:0]     own, own_n;
  logic [1:0]          l_op, l_op_n;
  logic                l_bad, l_bad_n;

  logic [NrOfBits-1:0] bus_wd_n, rdata_n;
  logic [NrOfRegs-1:0] reg_we_n, reg_cs_n, reg_clr_n, reg_pre_n;
  logic [NrOfReq-1:0]  grant_n, ack_n;
  logic                err_n, busy_n;

  logic [NrOfReq-1:0]  pick_grant;
  logic [IdxW-1:0]     pick_idx;
  logic                pick_found;

  logic [1:0]          p_op;
  logic [AddrBits-1:0] p_addr;
  logic [NrOfBits-1:0] p_wdata;
  logic [NrOfRegs-1:0] p_sel;
  logic                p_bad;

  rr_picker #(
    .NrOfReq(NrOfReq),
    .IdxW   (IdxW)
  ) u_picker (
    .req  (req),
    .ptr  (ptr),
    .grant(pick_grant),
    .idx  (pick_idx),
    .found(pick_found)
  );

  // Operands of the candidate winner; strobes are decoded from these so they
  // come out registered in the first ACCESS cycle.
  always_comb begin
    p_op    = '0;
    p_addr  = '0;
    p_wdata = '0;
    for (int k = 0; k < NrOfReq; k++) begin
      if (pick_grant[k]) begin
        p_op    = op[2*k +: 2];
        p_addr  = addr[AddrBits*k +: AddrBits];
        p_wdata = wdata[NrOfBits*k +: NrOfBits];
      end
    end
  end

  // An address with no matching register (>= NrOfRegs) leaves p_sel empty.
  always_comb begin
    p_sel = '0;
    for (int r = 0; r < NrOfRegs; r++) begin
      p_sel[r] = (int'(p_addr) == r);
    end
    p_bad = ~|p_sel;
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    own_n     = own;
    l_op_n    = l_op;
    l_bad_n   = l_bad;
    bus_wd_n  = bus_wd;
    rdata_n   = rdata;
    reg_we_n  = reg_we;
    reg_cs_n  = reg_cs;
    reg_clr_n = reg_clr;
    reg_pre_n = reg_pre;
    grant_n   = grant;
    ack_n     = ack;
    err_n     = err;
    busy_n    = busy;

    if (Tick) begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state_n = ACCESS;
            own_n   = pick_idx;
            grant_n = pick_grant;
            busy_n  = 1'b1;
            l_op_n  = p_op;
            l_bad_n = p_bad;
            case (p_op)
              OP_WRITE: begin
                reg_we_n = p_sel;
                bus_wd_n = p_wdata;
              end
              OP_READ: reg_cs_n  = ~p_sel;
              OP_CLR:  reg_clr_n = p_sel;
              OP_PRE:  reg_pre_n = p_sel;
              default: ;
            endcase
          end
        end
        ACCESS: begin
          state_n   = DONE;
          reg_we_n  = '0;
          reg_cs_n  = '1;
          reg_clr_n = '0;
          reg_pre_n = '0;
          ack_n     = grant;
          err_n     = l_bad;
          if (l_op == OP_READ && !l_bad) begin
            rdata_n = bus_rd;
          end
        end
        DONE: begin
          state_n = IDLE;
          ack_n   = '0;
          err_n   = 1'b0;
          grant_n = '0;
          busy_n  = 1'b0;
          if (int'(own) == NrOfReq - 1) begin
            ptr_n = '0;
          end else begin
            ptr_n = own + IdxW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      ptr     <= '0;
      own     <= '0;
      l_op    <= OP_READ;
      l_bad   <= 1'b0;
      bus_wd  <= '0;
      rdata   <= '0;
      reg_we  <= '0;
      reg_cs  <= '1;
      reg_clr <= '0;
      reg_pre <= '0;
      grant   <= '0;
      ack     <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      own     <= own_n;
      l_op    <= l_op_n;
      l_bad   <= l_bad_n;
      bus_wd  <= bus_wd_n;
      rdata   <= rdata_n;
      reg_we  <= reg_we_n;
      reg_cs  <= reg_cs_n;
      reg_clr <= reg_clr_n;
      reg_pre <= reg_pre_n;
      grant   <= grant_n;
      ack     <= ack_n;
      err     <= err_n;
      busy    <= busy_n;
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter
//   Directed bench for reg_bank_arbiter with a behavioural register bank
//   hanging off the strobes and the read bus.
module tb_reg_bank_arbiter;
  import reg_bank_arbiter_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Tick  = 1'b1;
  logic [3:0]  req   = '0;
  logic [7:0]  op;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [7:0]  bus_rd, bus_wd, reg_we, reg_cs, reg_clr, reg_pre, rdata;
  logic [3:0]  grant, ack;
  logic        err, busy;

  logic [1:0]  op_a    [4] = '{default: 2'd0};
  logic [3:0]  addr_a  [4] = '{default: 4'd0};
  logic [7:0]  wdata_a [4] = '{default: 8'd0};

  logic [7:0]  regs [8] = '{default: 8'h00};
  int          we_caps = 0;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign op[2*g +: 2]    = op_a[g];
    assign addr[4*g +: 4]  = addr_a[g];
    assign wdata[8*g +: 8] = wdata_a[g];
  end

  reg_bank_arbiter #(
    .NrOfReq (4),
    .NrOfRegs(8),
    .AddrBits(4),
    .NrOfBits(8)
  ) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Tick   (Tick),
    .req    (req),
    .op     (op),
    .addr   (addr),
    .wdata  (wdata),
    .bus_rd (bus_rd),
    .bus_wd (bus_wd),
    .reg_we (reg_we),
    .reg_cs (reg_cs),
    .reg_clr(reg_clr),
    .reg_pre(reg_pre),
    .grant  (grant),
    .ack    (ack),
    .err    (err),
    .rdata  (rdata),
    .busy   (busy)
  );

  always #5 Clock = ~Clock;

  // Register bank: ticked, clear beats preset beats write.
  always @(posedge Clock) begin
    if (Tick) begin
      for (int k = 0; k < 8; k++) begin
        if (reg_clr[k]) regs[k] <= 8'h00;
        else if (reg_pre[k]) regs[k] <= 8'hFF;
        else if (reg_we[k]) begin
          regs[k] <= bus_wd;
          we_caps <= we_caps + 1;
        end
      end
    end
  end

  always_comb begin
    bus_rd = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (!reg_cs[k]) bus_rd = regs[k];
    end
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Exclusivity of strobes and one-hot grant, every cycle out of reset.
  always @(negedge Clock) begin
    if (!Reset) begin
      chk("excl", 8'(($countones(~reg_cs) + $countones(reg_we) +
                      $countones(reg_clr) + $countones(reg_pre)) <= 1), 8'd1);
      chk("grant_1hot", 8'($onehot0(grant)), 8'd1);
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    req   = '0;
    step();
    step();
    Reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cs"},    reg_cs,  8'hFF);
    chk({tag, "_we"},    reg_we,  8'h00);
    chk({tag, "_clr"},   reg_clr, 8'h00);
    chk({tag, "_pre"},   reg_pre, 8'h00);
    chk({tag, "_grant"}, 8'(grant), 8'h00);
    chk({tag, "_ack"},   8'(ack),   8'h00);
    chk({tag, "_err"},   8'(err),   8'h00);
    chk({tag, "_busy"},  8'(busy),  8'h00);
    chk({tag, "_rdata"}, rdata,   8'h00);
    chk({tag, "_bus_wd"}, bus_wd, 8'h00);
  endtask

  // One transaction from an idle arbiter with Tick high: the current cycle is
  // cycle 0, strobes in cycle 1, ack in cycle 2, idle again in cycle 3.
  task automatic txn(input logic [1:0] r, input logic [1:0] o, input logic [3:0] a,
                     input logic [7:0] d, input logic [7:0] e_we, input logic [7:0] e_cs,
                     input logic [7:0] e_clr, input logic [7:0] e_pre,
                     input logic e_err, input logic [7:0] e_rd);
    op_a[r]    = o;
    addr_a[r]  = a;
    wdata_a[r] = d;
    req        = 4'b0001 << r;
    step();
    chk("c1_we",    reg_we,  e_we);
    chk("c1_cs",    reg_cs,  e_cs);
    chk("c1_clr",   reg_clr, e_clr);
    chk("c1_pre",   reg_pre, e_pre);
    chk("c1_grant", 8'(grant), 8'(4'b0001 << r));
    chk("c1_busy",  8'(busy),  8'd1);
    chk("c1_ack",   8'(ack),   8'd0);
    if (o == OP_WRITE) chk("c1_bus_wd", bus_wd, d);
    step();
    chk("c2_ack",   8'(ack),   8'(4'b0001 << r));
    chk("c2_err",   8'(err),   8'(e_err));
    chk("c2_cs",    reg_cs,  8'hFF);
    chk("c2_strb",  reg_we | reg_clr | reg_pre, 8'h00);
    if (o == OP_READ) chk("c2_rdata", rdata, e_rd);
    req = '0;
    step();
    chk("c3_busy",  8'(busy),  8'd0);
    chk("c3_ack",   8'(ack),   8'd0);
    chk("c3_grant", 8'(grant), 8'd0);
  endtask

  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int         caps0;

  initial begin
    do_reset();
    chk_reset_vals("rst");

    // write, readback
    txn(2'd1, OP_WRITE, 4'd3, 8'hA5, 8'h08, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00);
    txn(2'd2, OP_READ,  4'd3, 8'h00, 8'h00, 8'hF7, 8'h00, 8'h00, 1'b0, 8'hA5);

    // clear and preset
    txn(2'd0, OP_WRITE, 4'd5, 8'h5A, 8'h20, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00);
    txn(2'd3, OP_CLR,   4'd5, 8'h00, 8'h00, 8'hFF, 8'h20, 8'h00, 1'b0, 8'h00);
    txn(2'd1, OP_PRE,   4'd6, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h40, 1'b0, 8'h00);
    txn(2'd2, OP_READ,  4'd5, 8'h00, 8'h00, 8'hDF, 8'h00, 8'h00, 1'b0, 8'h00);
    txn(2'd0, OP_READ,  4'd6, 8'h00, 8'h00, 8'hBF, 8'h00, 8'h00, 1'b0, 8'hFF);

    // address range edges: 7 valid, 8 and 9 rejected, rdata held on bad read
    txn(2'd1, OP_PRE,   4'd7, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h80, 1'b0, 8'h00);
    txn(2'd2, OP_CLR,   4'd8, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b1, 8'h00);
    txn(2'd3, OP_WRITE, 4'd9, 8'h11, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b1, 8'h00);
    txn(2'd0, OP_READ,  4'd15, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b1, 8'hFF);

    // Tick stall during a write
    caps0      = we_caps;
    op_a[0]    = OP_WRITE;
    addr_a[0]  = 4'd2;
    wdata_a[0] = 8'h3C;
    req        = 4'b0001;
    step();
    chk("tk_we1", reg_we, 8'h04);
    Tick = 1'b0;
    step();
    chk("tk_we2", reg_we, 8'h04);
    chk("tk_ack2", 8'(ack), 8'd0);
    step();
    chk("tk_we3", reg_we, 8'h04);
    chk("tk_ack3", 8'(ack), 8'd0);
    Tick = 1'b1;
    step();
    chk("tk_ack4", 8'(ack), 8'd1);
    chk("tk_we4", reg_we, 8'h00);
    req = '0;
    step();
    chk("tk_caps", 8'(we_caps - caps0), 8'd1);
    txn(2'd3, OP_READ, 4'd2, 8'h00, 8'h00, 8'hFB, 8'h00, 8'h00, 1'b0, 8'h3C);

    // round robin with everybody requesting, pointer starts at 0 after reset
    do_reset();
    for (int k = 0; k < 4; k++) begin
      op_a[k]   = OP_READ;
      addr_a[k] = 4'(k);
    end
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      step();
      chk("rr_grant", 8'(grant), 8'(rr_exp[n]));
      step();
      chk("rr_ack", 8'(ack), 8'(rr_exp[n]));
      step();
      chk("rr_idle", 8'(busy), 8'd0);
    end
    req = '0;
    step();

    // reset during ACCESS
    op_a[2]    = OP_WRITE;
    addr_a[2]  = 4'd1;
    wdata_a[2] = 8'h77;
    req        = 4'b0100;
    step();
    chk("ra_we", reg_we, 8'h02);
    Reset = 1'b1;
    step();
    chk_reset_vals("ra");
    Reset = 1'b0;
    req   = '0;
    step();
    chk("ra_noack1", 8'(ack), 8'd0);
    step();
    chk("ra_noack2", 8'(ack), 8'd0);
    chk("ra_busy", 8'(busy), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
